prbs_checker: RTL and testbench

- Hardware receive end of the board's pseudo-random data path: consumes an 8-bit PRBS-7 word stream (x^7+x^6+1) from a generator or a loopback link.
- Self-synchronises its local LFSR to the stream and declares lock.
- Counts bit and word errors for LED/UART status reporting on the board.
- Replaces simulation-only $random checking with synthesizable, on-board verification.

---
 rtl/prbs_pkg.sv | 27 ++
 rtl/prbs_checker_popcount.sv | 13 +
 rtl/prbs_checker.sv | 103 ++++++++++
 tb/tb_prbs_checker.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// prbs_pkg: shared PRBS-7 (x^7+x^6+1) types, tap constants and LFSR stepping function
package prbs_pkg;
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
  localparam int PRBS_W = 7;
  localparam int TAP_HI = 6;
  localparam int TAP_LO = 5;
  localparam int PRBS_MAX_BITS = 8;
  typedef struct packed {
    logic [PRBS_W-1:0] s;
    logic [PRBS_MAX_BITS-1:0] bits;
  } prbs_step_t;
  // Steps the LFSR n times; the first generated bit lands at bits[n-1], the last at bits[0].
  function automatic prbs_step_t prbs_advance(input logic [PRBS_W-1:0] state, input int unsigned n);
    prbs_step_t r;
    logic nb;
    r.s = state;
    r.bits = '0;
    for (int i = 0; i < PRBS_MAX_BITS; i++) begin
      if (i < n) begin
        nb = r.s[TAP_HI] ^ r.s[TAP_LO];
        r.s = {r.s[PRBS_W-2:0], nb};
        r.bits = {r.bits[PRBS_MAX_BITS-2:0], nb};
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/prbs_checker_popcount.sv
// popcount: combinational count of set bits; data in, count out
module popcount #(
  parameter int W = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  data,
  output logic [CW-1:0] count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) count = count + CW'(data[i]);
  end
endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS-7 word checker; clk/rst/clear/in_valid/in_data in, locked/lock_lost/err_pulse/word_cnt/err_bit_cnt out
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LFSR_W = 7,
  parameter int LOCK_CNT = 4,
  parameter int UNLOCK_CNT = 4,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              locked,
  output logic              lock_lost,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  err_bit_cnt
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);
  localparam logic [MW-1:0] LOCK_M = MW'(LOCK_CNT);
  localparam logic [BW-1:0] UNLOCK_M = BW'(UNLOCK_CNT);
  state_t state, state_n;
  logic [LFSR_W-1:0] p, p_n, seed;
  logic [MW-1:0] match_cnt, match_n, match_inc;
  logic [BW-1:0] bad_cnt, bad_n, bad_inc;
  logic [DATA_W-1:0] exp_data;
  logic [CW-1:0] e;
  prbs_step_t pred;
  logic hit, bit_err, unlock, chk;
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction
  // Prediction always advances from the local state, never from received data.
  assign pred = prbs_advance(p, DATA_W);
  assign exp_data = pred.bits[DATA_W-1:0];
  // The low LFSR_W bits of a word are exactly the generator state after it.
  assign seed = in_data[LFSR_W-1:0];
  assign hit = in_data == exp_data;
  assign bit_err = e != '0;
  assign match_inc = match_cnt + MW'(1);
  assign bad_inc = bad_cnt + BW'(1);
  assign chk = in_valid && state == LOCKED;
  assign locked = state == LOCKED;
  popcount #(.W(DATA_W), .CW(CW)) u_pop (.data(in_data ^ exp_data), .count(e));
  always_comb begin
    state_n = state;
    p_n = p;
    match_n = match_cnt;
    bad_n = bad_cnt;
    unlock = 1'b0;
    if (in_valid) begin
      case (state)
        HUNT: begin
          state_n = VERIFY;
          p_n = seed;
          match_n = '0;
        end
        VERIFY: begin
          p_n = hit ? pred.s : seed;
          match_n = hit ? match_inc : '0;
          state_n = (hit && match_inc == LOCK_M) ? LOCKED : VERIFY;
          bad_n = '0;
        end
        LOCKED: begin
          p_n = pred.s;
          bad_n = bit_err ? bad_inc : '0;
          unlock = bit_err && bad_inc == UNLOCK_M;
          state_n = unlock ? HUNT : LOCKED;
        end
        default: state_n = HUNT;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
      p <= '0;
      match_cnt <= '0;
      bad_cnt <= '0;
      lock_lost <= 1'b0;
      err_pulse <= 1'b0;
      word_cnt <= '0;
      err_bit_cnt <= '0;
    end else begin
      state <= state_n;
      p <= p_n;
      match_cnt <= match_n;
      bad_cnt <= bad_n;
      err_pulse <= chk && bit_err;
      // An unlock on the clearing word still leaves lock_lost set.
      lock_lost <= unlock ? 1'b1 : clear ? 1'b0 : lock_lost;
      word_cnt <= clear ? '0 : chk ? sat_add(word_cnt, CNT_W'(1)) : word_cnt;
      err_bit_cnt <= clear ? '0 : chk ? sat_add(err_bit_cnt, CNT_W'(e)) : err_bit_cnt;
    end
  end
endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed self-checking bench for prbs_checker
module tb_prbs_checker;
  import prbs_pkg::*;
  logic clk = 1'b0;
  logic rst, clear, in_valid;
  logic [7:0] in_data;
  logic locked, lock_lost, err_pulse;
  logic [31:0] word_cnt, err_bit_cnt;
  logic [6:0] g;
  int n_vec = 0;
  int n_err = 0;
  int post_lock;
  prbs_checker dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .locked(locked), .lock_lost(lock_lost), .err_pulse(err_pulse),
    .word_cnt(word_cnt), .err_bit_cnt(err_bit_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  function automatic logic [7:0] gen_word();
    logic [7:0] w;
    logic nb;
    for (int i = 0; i < 8; i++) begin
      nb = g[6] ^ g[5];
      g = {g[5:0], nb};
      w = {w[6:0], nb};
    end
    return w;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data = d;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    clear = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_locked", {31'b0, locked}, 32'd0);
    check("rst_lock_lost", {31'b0, lock_lost}, 32'd0);
    check("rst_err_pulse", {31'b0, err_pulse}, 32'd0);
    check("rst_word_cnt", word_cnt, 32'd0);
    check("rst_err_bit_cnt", err_bit_cnt, 32'd0);
    // 1: acquire lock from seed 7'h01
    g = 7'h01;
    for (int i = 0; i < 4; i++) send(gen_word());
    check("t1_not_yet_locked", {31'b0, locked}, 32'd0);
    send(gen_word());
    check("t1_locked", {31'b0, locked}, 32'd1);
    check("t1_word_cnt0", word_cnt, 32'd0);
    for (int i = 0; i < 3; i++) send(gen_word());
    check("t1_word_cnt3", word_cnt, 32'd3);
    check("t1_err_bits", err_bit_cnt, 32'd0);
    // 2: single word with three flipped bits
    send(gen_word() ^ 8'h07);
    check("t2_err_pulse", {31'b0, err_pulse}, 32'd1);
    check("t2_err_bits", err_bit_cnt, 32'd3);
    check("t2_locked", {31'b0, locked}, 32'd1);
    tick();
    check("t2_pulse_one_cycle", {31'b0, err_pulse}, 32'd0);
    for (int i = 0; i < 5; i++) send(gen_word());
    check("t2_err_bits_hold", err_bit_cnt, 32'd3);
    check("t2_word_cnt", word_cnt, 32'd9);
    check("t2_no_pulse", {31'b0, err_pulse}, 32'd0);
    // 3: four inverted words drop lock
    pulse_clear();
    check("t3_clear_cnt", word_cnt, 32'd0);
    for (int i = 0; i < 3; i++) begin
      send(gen_word() ^ 8'hFF);
      check("t3_pulse", {31'b0, err_pulse}, 32'd1);
      check("t3_still_locked", {31'b0, locked}, 32'd1);
    end
    send(gen_word() ^ 8'hFF);
    check("t3_pulse4", {31'b0, err_pulse}, 32'd1);
    check("t3_err_bits", err_bit_cnt, 32'd32);
    check("t3_word_cnt", word_cnt, 32'd4);
    check("t3_unlocked", {31'b0, locked}, 32'd0);
    check("t3_lock_lost", {31'b0, lock_lost}, 32'd1);
    for (int i = 0; i < 4; i++) send(gen_word());
    check("t3_relock_early", {31'b0, locked}, 32'd0);
    send(gen_word());
    check("t3_relocked", {31'b0, locked}, 32'd1);
    check("t3_lock_lost_sticky", {31'b0, lock_lost}, 32'd1);
    pulse_clear();
    check("t3_lock_lost_cleared", {31'b0, lock_lost}, 32'd0);
    check("t3_err_bits_cleared", err_bit_cnt, 32'd0);
    // 4: random idle gaps
    post_lock = 0;
    for (int i = 0; i < 1000; i++) begin
      send(gen_word());
      post_lock++;
      for (int k = $urandom_range(0, 5); k > 0; k--) tick();
    end
    check("t4_word_cnt", word_cnt, post_lock);
    check("t4_err_bits", err_bit_cnt, 32'd0);
    check("t4_locked", {31'b0, locked}, 32'd1);
    check("t4_lock_lost", {31'b0, lock_lost}, 32'd0);
    // 5: clear beats an erroneous word, then saturation
    clear = 1'b1;
    send(gen_word() ^ 8'h0F);
    clear = 1'b0;
    check("t5_clear_err_bits", err_bit_cnt, 32'd0);
    check("t5_clear_word_cnt", word_cnt, 32'd0);
    force dut.err_bit_cnt = 32'hFFFF_FFFD;
    force dut.word_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.err_bit_cnt;
    release dut.word_cnt;
    send(gen_word() ^ 8'hFF);
    check("t5_sat_err_bits", err_bit_cnt, 32'hFFFF_FFFF);
    check("t5_word_cnt_max", word_cnt, 32'hFFFF_FFFF);
    send(gen_word());
    check("t5_sat_word_cnt", word_cnt, 32'hFFFF_FFFF);
    check("t5_sat_err_hold", err_bit_cnt, 32'hFFFF_FFFF);
    check("t5_locked", {31'b0, locked}, 32'd1);
    // 6: reset while locked with a valid word
    rst = 1'b1;
    send(gen_word() ^ 8'hFF);
    rst = 1'b0;
    check("t6_locked", {31'b0, locked}, 32'd0);
    check("t6_word_cnt", word_cnt, 32'd0);
    check("t6_err_bits", err_bit_cnt, 32'd0);
    check("t6_err_pulse", {31'b0, err_pulse}, 32'd0);
    check("t6_state", {30'b0, dut.state}, {30'b0, HUNT});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
